// File: rtl/umem_arbiter.sv
// Shares one single-port I/D memory between fetch (IF) and load/store (MEM).
// DM has priority; a saturating streak counter forces an IF grant after MAX_DM DM wins.
module umem_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int MAX_DM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [AW-1:0]     if_addr,
  input  logic              if_flush,
  output logic [DW-1:0]     if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [AW-1:0]     dm_addr,
  input  logic [DW-1:0]     dm_wdata,
  input  logic [DW/8-1:0]   dm_wmask,
  output logic [DW-1:0]     dm_rdata,
  output logic              dm_ready,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic [DW/8-1:0]   mem_wmask,
  input  logic [DW-1:0]     mem_rdata,
  input  logic              mem_ack
);

  localparam int SW = $clog2(MAX_DM + 1);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  state_t        state;
  logic [SW-1:0] streak;
  logic          drop;

  logic if_elig, dm_elig, streak_full, grant_if, grant_dm;

  function automatic logic [SW-1:0] streak_inc(input logic [SW-1:0] s);
    return (s == SW'(MAX_DM)) ? s : s + SW'(1);
  endfunction

  // A requester whose ready pulse is high this cycle is never re-granted.
  always_comb begin
    if_elig     = if_req & ~if_ready & ~if_flush;
    dm_elig     = dm_req & ~dm_ready;
    streak_full = (streak == SW'(MAX_DM));
    grant_if    = (state == IDLE) & if_elig & (streak_full | ~dm_elig);
    grant_dm    = (state == IDLE) & dm_elig & ~grant_if;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      streak    <= '0;
      drop      <= 1'b0;
      if_rdata  <= '0;
      if_ready  <= 1'b0;
      dm_rdata  <= '0;
      dm_ready  <= 1'b0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
    end else begin
      if_ready <= 1'b0;
      dm_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_if) begin
            state     <= BUSY_IF;
            streak    <= '0;
            mem_valid <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wmask <= '0;
          end else if (grant_dm) begin
            state     <= BUSY_DM;
            if (if_elig) streak <= streak_inc(streak);
            mem_valid <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_wmask <= dm_wmask;
          end
        end
        BUSY_IF: begin
          // A flush landing with the ack still kills the fetch result.
          if (mem_ack) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            drop      <= 1'b0;
            if (!(drop || if_flush)) begin
              if_ready <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else if (if_flush) begin
            drop <= 1'b1;
          end
        end
        BUSY_DM: begin
          if (mem_ack) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            dm_ready  <= 1'b1;
            if (!mem_we) dm_rdata <= mem_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_umem_arbiter.sv
// Directed bench for umem_arbiter: transaction-level reference model checked every cycle,
// plus hand-computed expectations for each scenario.
module tb_umem_arbiter;
  localparam int AW = 32, DW = 32, MAX_DM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0, if_flush = 1'b0, if_ready;
  logic [31:0]   if_addr = '0, if_rdata;
  logic          dm_req = 1'b0, dm_we = 1'b0, dm_ready;
  logic [31:0]   dm_addr = '0, dm_wdata = '0, dm_rdata;
  logic [3:0]    dm_wmask = '0;
  logic          mem_valid, mem_we, mem_ack = 1'b0;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata = '0;
  logic [3:0]    mem_wmask;

  int n_chk = 0, n_fail = 0;
  int cfg_wait = 0, wcnt = 0;

  umem_arbiter #(.AW(AW), .DW(DW), .MAX_DM(MAX_DM)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wmask(dm_wmask), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a == 32'h100) ? 32'h00500093 : ((a * 32'd2654435761) ^ 32'h13579BDF);
  endfunction

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory: acks after cfg_wait stall cycles, data is a pure function of the address.
  initial forever begin
    @(posedge clk); #2;
    if (mem_valid) begin
      if (wcnt >= cfg_wait) begin
        mem_ack = 1'b1; mem_rdata = memfn(mem_addr); wcnt = 0;
      end else begin
        mem_ack = 1'b0; mem_rdata = 32'hBAD0BAD0; wcnt++;
      end
    end else begin
      mem_ack = 1'b0; mem_rdata = 32'hBAD0BAD0; wcnt = 0;
    end
  end

  // Reference model: owner 0 = memory free, 1 = fetch in flight, 2 = load/store in flight.
  int          m_owner = 0, m_streak = 0;
  bit          m_drop = 0, m_valid = 0, m_we = 0, m_ifr = 0, m_dmr = 0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_ifd = '0, m_dmd = '0;
  logic [3:0]  m_wmask = '0;
  bit          t_ie, t_de, t_oifr, t_odmr;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = 0; m_streak = 0; m_drop = 0; m_valid = 0; m_we = 0;
      m_ifr = 0; m_dmr = 0; m_addr = '0; m_wdata = '0; m_wmask = '0;
      m_ifd = '0; m_dmd = '0;
    end else begin
      t_oifr = m_ifr; t_odmr = m_dmr;
      m_ifr = 0; m_dmr = 0;
      if (m_owner == 0) begin
        t_ie = if_req && !t_oifr && !if_flush;
        t_de = dm_req && !t_odmr;
        if (t_ie && (!t_de || m_streak == MAX_DM)) begin
          m_owner = 1; m_valid = 1; m_we = 0; m_wmask = '0; m_addr = if_addr;
          m_streak = 0;
        end else if (t_de) begin
          m_owner = 2; m_valid = 1; m_we = dm_we; m_wmask = dm_wmask;
          m_addr = dm_addr; m_wdata = dm_wdata;
          if (t_ie && m_streak < MAX_DM) m_streak++;
        end
      end else if (mem_ack) begin
        if (m_owner == 1) begin
          if (!m_drop && !if_flush) begin m_ifr = 1; m_ifd = mem_rdata; end
          m_drop = 0;
        end else begin
          m_dmr = 1;
          if (!m_we) m_dmd = mem_rdata;
        end
        m_owner = 0; m_valid = 0;
      end else if (m_owner == 1 && if_flush) begin
        m_drop = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk1("mem_valid", mem_valid, m_valid);
    chk1("if_ready", if_ready, m_ifr);
    chk1("dm_ready", dm_ready, m_dmr);
    chk32("if_rdata", if_rdata, m_ifd);
    chk32("dm_rdata", dm_rdata, m_dmd);
    if (m_valid) begin
      chk32("mem_addr", mem_addr, m_addr);
      chk1("mem_we", mem_we, m_we);
      chk32("mem_wmask", 32'(mem_wmask), 32'(m_wmask));
      if (m_we) chk32("mem_wdata", mem_wdata, m_wdata);
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; if_req = 1'b0; dm_req = 1'b0; if_flush = 1'b0; dm_we = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  string seq;
  bit    prev_v;

  initial begin
    tick; tick;
    chk1("rst_mem_valid", mem_valid, 1'b0);
    chk1("rst_if_ready", if_ready, 1'b0);
    chk1("rst_dm_ready", dm_ready, 1'b0);
    chk32("rst_mem_addr", mem_addr, 32'h0);
    chk32("rst_if_rdata", if_rdata, 32'h0);
    rst = 1'b0;

    // IF only, zero wait, then re-grant for the next address
    if_req = 1'b1; if_addr = 32'h100; tick;
    chk1("A_valid", mem_valid, 1'b1); chk32("A_addr", mem_addr, 32'h100); chk1("A_we", mem_we, 1'b0);
    tick;
    chk1("A_ready", if_ready, 1'b1); chk32("A_rdata", if_rdata, 32'h00500093);
    if_addr = 32'h104; tick;
    chk1("A_gap", mem_valid, 1'b0); chk1("A_ready_pulse", if_ready, 1'b0);
    tick;
    chk1("A_regrant", mem_valid, 1'b1); chk32("A_addr2", mem_addr, 32'h104);
    tick;
    chk1("A_ready2", if_ready, 1'b1);
    if_req = 1'b0; tick;

    // Flush in the second BUSY_IF cycle
    cfg_wait = 2; if_req = 1'b1; if_addr = 32'h500; tick;
    chk1("E_valid", mem_valid, 1'b1);
    tick;
    if_flush = 1'b1; if_addr = 32'h600; tick;
    if_flush = 1'b0; cfg_wait = 0;
    chk1("E_busy", mem_valid, 1'b1); chk32("E_hold_addr", mem_addr, 32'h500);
    tick;
    chk1("E_no_ready", if_ready, 1'b0); chk1("E_idle", mem_valid, 1'b0);
    chk32("E_rdata_kept", if_rdata, memfn(32'h104));
    tick;
    chk1("E_new_grant", mem_valid, 1'b1); chk32("E_new_addr", mem_addr, 32'h600);
    tick;
    chk1("E_ready", if_ready, 1'b1); chk32("E_rdata", if_rdata, memfn(32'h600));
    if_req = 1'b0; tick;

    // IF and DM together: DM first, IF in the dm_ready cycle
    do_reset;
    cfg_wait = 0; if_req = 1'b1; if_addr = 32'h200;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000; tick;
    chk1("B_valid", mem_valid, 1'b1); chk32("B_dm_addr", mem_addr, 32'h2000);
    tick;
    chk1("B_dm_ready", dm_ready, 1'b1); chk32("B_dm_rdata", dm_rdata, memfn(32'h2000));
    dm_req = 1'b0; tick;
    chk1("B_if_valid", mem_valid, 1'b1); chk32("B_if_addr", mem_addr, 32'h200);
    tick;
    chk1("B_if_ready", if_ready, 1'b1); chk32("B_if_rdata", if_rdata, memfn(32'h200));
    if_req = 1'b0; tick;

    // Store with three wait states; dm_rdata keeps the earlier load
    cfg_wait = 3; dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h3000;
    dm_wdata = 32'hDEADBEEF; dm_wmask = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk1("C_valid", mem_valid, 1'b1); chk1("C_we", mem_we, 1'b1);
      chk32("C_wmask", 32'(mem_wmask), 32'h3); chk1("C_not_ready", dm_ready, 1'b0);
    end
    tick;
    chk1("C_ready", dm_ready, 1'b1); chk32("C_rdata_kept", dm_rdata, memfn(32'h2000));
    dm_req = 1'b0; dm_we = 1'b0; dm_wmask = '0; tick;
    chk1("C_ready_pulse", dm_ready, 1'b0);

    // Streak: flush on each dm_ready cycle keeps IF waiting-but-ungranted there
    do_reset;
    cfg_wait = 0; if_req = 1'b1; if_addr = 32'h400;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h9000;
    seq = ""; prev_v = 1'b0;
    for (int cyc = 0; cyc < 200 && seq.len() < 11; cyc++) begin
      tick;
      if (mem_valid && !prev_v) begin
        if (mem_addr >= 32'h8000) seq = {seq, "D"};
        else seq = {seq, "I"};
      end
      prev_v = mem_valid;
      if_flush = dm_ready;
      if (dm_ready) dm_addr += 4;
      if (if_ready) if_addr += 4;
    end
    n_chk++;
    if (seq != "DDDDIDDDDDI") begin
      n_fail++;
      $display("FAIL streak_seq: got %s expected DDDDIDDDDDI", seq);
    end
    if_req = 1'b0; dm_req = 1'b0; if_flush = 1'b0;
    tick; tick; tick;

    // Reset while a load is waiting for its ack
    do_reset;
    cfg_wait = 5; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h7000;
    if_req = 1'b1; if_addr = 32'h700; tick;
    chk1("F_valid", mem_valid, 1'b1); chk32("F_addr", mem_addr, 32'h7000);
    tick;
    rst = 1'b1; #1;
    chk1("F_rst_valid", mem_valid, 1'b0); chk1("F_rst_dm_ready", dm_ready, 1'b0);
    chk32("F_rst_addr", mem_addr, 32'h0);
    if_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; cfg_wait = 0;
    tick;
    chk1("F_regrant", mem_valid, 1'b1); chk32("F_addr2", mem_addr, 32'h7000);
    tick;
    chk1("F_ready", dm_ready, 1'b1); chk32("F_rdata", dm_rdata, memfn(32'h7000));
    dm_req = 1'b0; tick; tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required self-termination");
    $fatal(1);
  end

endmodule
